// File: rtl/msr_file_v2_pkg.sv
// Shared encodings for the machine status register file: software op codes,
// fixed register indices and MSTATUS bit positions.
package msr_file_v2_pkg;

    typedef enum logic [1:0] {
        MSR_OP_NONE  = 2'b00,
        MSR_OP_WRITE = 2'b01,
        MSR_OP_SET   = 2'b10,
        MSR_OP_CLEAR = 2'b11
    } msr_op_e;

    localparam int MSR_MSTATUS = 0;
    localparam int MSR_MTVEC   = 1;
    localparam int MSR_MEPC    = 2;
    localparam int MSR_MCAUSE  = 3;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

endpackage

// File: rtl/msr_counter64.sv
// Double-width free-running counter with independent lo/hi half replacement.
// Any half write takes the cycle and suppresses that cycle's increment.
module msr_counter64 #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              we_lo,
    input  logic              we_hi,
    input  logic [XLEN-1:0]   wdata,
    output logic [2*XLEN-1:0] value
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (we_lo || we_hi) begin
            if (we_lo) value[XLEN-1:0]      <= wdata;
            if (we_hi) value[2*XLEN-1:XLEN] <= wdata;
        end else if (inc) begin
            value <= value + (2*XLEN)'(1);
        end
    end

endmodule

// File: rtl/msr_file_v2.sv
// Machine status register file: combinational read, write/set/clear RMW port,
// trap capture and mret restore. Define MSR_COUNTERS_EN for CYCLE/INSTRET counters.
module msr_file_v2
    import msr_file_v2_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic [1:0]        I_op,
    input  logic [ADDR_W-1:0] I_addr,
    input  logic [XLEN-1:0]   I_wdata,
    output logic [XLEN-1:0]   O_data,
    output logic              O_illegal,
    input  logic              I_trap,
    input  logic [XLEN-1:0]   I_trap_pc,
    input  logic [XLEN-1:0]   I_trap_cause,
    input  logic              I_mret,
    input  logic              I_retire,
    output logic [XLEN-1:0]   O_mtvec,
    output logic [XLEN-1:0]   O_mepc,
    output logic              O_mie
);

`ifdef MSR_COUNTERS_EN
    localparam int IDX_CYC_LO = NUM_REGS - 4;
    localparam int IDX_CYC_HI = NUM_REGS - 3;
    localparam int IDX_INS_LO = NUM_REGS - 2;
    localparam int IDX_INS_HI = NUM_REGS - 1;
    localparam int SCR_LAST   = NUM_REGS - 5;
`else
    localparam int SCR_LAST   = NUM_REGS - 1;
`endif

    function automatic logic [XLEN-1:0] pack_mstatus(input logic ie, input logic pie);
        logic [XLEN-1:0] v;
        v               = '0;
        v[MSTATUS_MIE]  = ie;
        v[MSTATUS_MPIE] = pie;
        return v;
    endfunction

    function automatic logic [XLEN-1:0] mask_mtvec(input logic [XLEN-1:0] v);
        return {v[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] mask_mepc(input logic [XLEN-1:0] v);
        return {v[XLEN-1:1], 1'b0};
    endfunction

    msr_op_e         op;
    int              addr_idx;
    logic            addr_ok;
    logic            sw_en;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] rmw_val;

    logic            mie;
    logic            mpie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] scratch [2**ADDR_W];

    logic wr_mstatus, wr_mtvec, wr_mepc, wr_mcause, wr_scratch;

    assign op       = msr_op_e'(I_op);
    assign addr_idx = int'(I_addr);
    assign addr_ok  = (addr_idx < NUM_REGS);

`ifdef MSR_COUNTERS_EN
    logic [2*XLEN-1:0] cycle;
    logic [2*XLEN-1:0] instret;

    msr_counter64 #(.XLEN(XLEN)) u_cycle (
        .clk   (I_clk),
        .rst_n (I_rst),
        .inc   (1'b1),
        .we_lo (sw_en && addr_idx == IDX_CYC_LO),
        .we_hi (sw_en && addr_idx == IDX_CYC_HI),
        .wdata (rmw_val),
        .value (cycle)
    );

    msr_counter64 #(.XLEN(XLEN)) u_instret (
        .clk   (I_clk),
        .rst_n (I_rst),
        .inc   (I_retire),
        .we_lo (sw_en && addr_idx == IDX_INS_LO),
        .we_hi (sw_en && addr_idx == IDX_INS_HI),
        .wdata (rmw_val),
        .value (instret)
    );
`else
    logic unused_retire;
    assign unused_retire = I_retire;
`endif

    // Unimplemented indices read as zero, so rd_val doubles as the O_data value.
    always_comb begin
        rd_val = '0;
        if (addr_ok) begin
            if (addr_idx == MSR_MSTATUS)     rd_val = pack_mstatus(mie, mpie);
            else if (addr_idx == MSR_MTVEC)  rd_val = mtvec;
            else if (addr_idx == MSR_MEPC)   rd_val = mepc;
            else if (addr_idx == MSR_MCAUSE) rd_val = mcause;
`ifdef MSR_COUNTERS_EN
            else if (addr_idx == IDX_CYC_LO) rd_val = cycle[XLEN-1:0];
            else if (addr_idx == IDX_CYC_HI) rd_val = cycle[2*XLEN-1:XLEN];
            else if (addr_idx == IDX_INS_LO) rd_val = instret[XLEN-1:0];
            else if (addr_idx == IDX_INS_HI) rd_val = instret[2*XLEN-1:XLEN];
`endif
            else                             rd_val = scratch[I_addr];
        end
    end

    always_comb begin
        rmw_val = rd_val;
        case (op)
            MSR_OP_WRITE: rmw_val = I_wdata;
            MSR_OP_SET:   rmw_val = rd_val | I_wdata;
            MSR_OP_CLEAR: rmw_val = rd_val & ~I_wdata;
            default:      rmw_val = rd_val;
        endcase
    end

    // A zero set/clear mask is a no-op, not a rewrite of the current value.
    assign sw_en = addr_ok &&
                   (op == MSR_OP_WRITE || (op != MSR_OP_NONE && I_wdata != '0));

    assign wr_mstatus = sw_en && addr_idx == MSR_MSTATUS;
    assign wr_mtvec   = sw_en && addr_idx == MSR_MTVEC;
    assign wr_mepc    = sw_en && addr_idx == MSR_MEPC;
    assign wr_mcause  = sw_en && addr_idx == MSR_MCAUSE;
    assign wr_scratch = sw_en && addr_idx > MSR_MCAUSE && addr_idx <= SCR_LAST;

    // Trap outranks mret, which outranks a software op on the same entry.
    always_ff @(posedge I_clk) begin
        if (!I_rst) begin
            mie    <= 1'b0;
            mpie   <= 1'b0;
            mtvec  <= '0;
            mepc   <= '0;
            mcause <= '0;
        end else begin
            if (I_trap) begin
                mpie <= mie;
                mie  <= 1'b0;
            end else if (I_mret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (wr_mstatus) begin
                mie  <= rmw_val[MSTATUS_MIE];
                mpie <= rmw_val[MSTATUS_MPIE];
            end

            if (wr_mtvec) mtvec <= mask_mtvec(rmw_val);

            if (I_trap)       mepc <= mask_mepc(I_trap_pc);
            else if (wr_mepc) mepc <= mask_mepc(rmw_val);

            if (I_trap)         mcause <= I_trap_cause;
            else if (wr_mcause) mcause <= rmw_val;
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) scratch[i] <= '0;
        end else if (wr_scratch) begin
            scratch[I_addr] <= rmw_val;
        end
    end

    assign O_data    = rd_val;
    assign O_illegal = !addr_ok && op != MSR_OP_NONE;
    assign O_mtvec   = mtvec;
    assign O_mepc    = mepc;
    assign O_mie     = mie;

endmodule

// File: tb/tb_msr_file_v2.sv
// Directed self-checking bench for msr_file_v2: a full-size instance plus a
// NUM_REGS=12 instance for unimplemented-index handling; follows MSR_COUNTERS_EN.
module tb_msr_file_v2;
    import msr_file_v2_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  op;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        mret;
    logic        retire;
    logic [31:0] data;
    logic        illegal;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mie;

    logic [1:0]  op12;
    logic [3:0]  addr12;
    logic [31:0] wdata12;
    logic [31:0] data12;
    logic        illegal12;
    logic [31:0] mtvec12;
    logic [31:0] mepc12;
    logic        mie12;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    msr_file_v2 #(.XLEN(32), .ADDR_W(4), .NUM_REGS(16)) dut (
        .I_clk        (clk),
        .I_rst        (rst),
        .I_op         (op),
        .I_addr       (addr),
        .I_wdata      (wdata),
        .O_data       (data),
        .O_illegal    (illegal),
        .I_trap       (trap),
        .I_trap_pc    (trap_pc),
        .I_trap_cause (trap_cause),
        .I_mret       (mret),
        .I_retire     (retire),
        .O_mtvec      (mtvec),
        .O_mepc       (mepc),
        .O_mie        (mie)
    );

    msr_file_v2 #(.XLEN(32), .ADDR_W(4), .NUM_REGS(12)) dut12 (
        .I_clk        (clk),
        .I_rst        (rst),
        .I_op         (op12),
        .I_addr       (addr12),
        .I_wdata      (wdata12),
        .O_data       (data12),
        .O_illegal    (illegal12),
        .I_trap       (1'b0),
        .I_trap_pc    (32'h0),
        .I_trap_cause (32'h0),
        .I_mret       (1'b0),
        .I_retire     (1'b0),
        .O_mtvec      (mtvec12),
        .O_mepc       (mepc12),
        .O_mie        (mie12)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [1:0] o, input logic [3:0] a, input logic [31:0] d);
        op    = o;
        addr  = a;
        wdata = d;
        tick();
        op    = MSR_OP_NONE;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        #1;
        chk(tag, data, exp);
    endtask

    task automatic rd12(input logic [3:0] a, input logic [31:0] exp, input string tag);
        addr12 = a;
        #1;
        chk(tag, data12, exp);
    endtask

    initial begin
        rst = 1'b0; op = MSR_OP_NONE; addr = '0; wdata = '0;
        trap = 1'b0; trap_pc = '0; trap_cause = '0; mret = 1'b0; retire = 1'b0;
        op12 = MSR_OP_NONE; addr12 = '0; wdata12 = '0;

        // Reset state
        tick();
        rst = 1'b1;
`ifdef MSR_COUNTERS_EN
        for (int i = 0; i < 12; i++) rd(4'(i), 32'h0, $sformatf("reset_idx%0d", i));
`else
        for (int i = 0; i < 16; i++) rd(4'(i), 32'h0, $sformatf("reset_idx%0d", i));
`endif
        chk("reset_mie", {31'h0, mie}, 32'h0);
        chk("reset_mtvec", mtvec, 32'h0);
        chk("reset_mepc", mepc, 32'h0);

        // Write masking, set/clear of MIE
        do_op(MSR_OP_WRITE, 4'd1, 32'h0000_1003);
        rd(4'd1, 32'h0000_1000, "mtvec_read_masked");
        chk("mtvec_port", mtvec, 32'h0000_1000);
        do_op(MSR_OP_SET, 4'd0, 32'h8);
        chk("mie_after_set", {31'h0, mie}, 32'h1);
        rd(4'd0, 32'h8, "mstatus_after_set");
        do_op(MSR_OP_CLEAR, 4'd0, 32'h8);
        chk("mie_after_clear", {31'h0, mie}, 32'h0);
        do_op(MSR_OP_WRITE, 4'd0, 32'hFFFF_FFFF);
        rd(4'd0, 32'h88, "mstatus_only_mie_mpie");
        do_op(MSR_OP_SET, 4'd1, 32'h0);
        rd(4'd1, 32'h0000_1000, "set_zero_mask_noop");
        do_op(MSR_OP_WRITE, 4'd0, 32'h8);
        rd(4'd0, 32'h8, "mstatus_mie_only");

        // Trap capture and mret
        trap = 1'b1; trap_pc = 32'h0000_0105; trap_cause = 32'hB;
        tick();
        trap = 1'b0;
        rd(4'd2, 32'h0000_0104, "trap_mepc_read");
        chk("trap_mepc_port", mepc, 32'h0000_0104);
        rd(4'd3, 32'hB, "trap_mcause");
        chk("trap_mie", {31'h0, mie}, 32'h0);
        rd(4'd0, 32'h80, "trap_mstatus");
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("mret_mie", {31'h0, mie}, 32'h1);
        rd(4'd0, 32'h88, "mret_mstatus");

        // Trap versus software op in the same cycle
        trap = 1'b1; trap_pc = 32'h0000_0200; trap_cause = 32'h5;
        do_op(MSR_OP_WRITE, 4'd2, 32'hFFFF);
        trap = 1'b0;
        rd(4'd2, 32'h0000_0200, "trap_beats_mepc_write");
        rd(4'd3, 32'h5, "trap2_mcause");
        trap = 1'b1; trap_pc = 32'h0000_0301; trap_cause = 32'h6;
        do_op(MSR_OP_WRITE, 4'd4, 32'hFFFF);
        trap = 1'b0;
        rd(4'd4, 32'h0000_FFFF, "scratch_write_beside_trap");
        rd(4'd2, 32'h0000_0300, "trap3_mepc");
        mret = 1'b1;
        do_op(MSR_OP_WRITE, 4'd0, 32'h8);
        mret = 1'b0;
        rd(4'd0, 32'h80, "mret_beats_mstatus_write");
        chk("mret_beats_write_mie", {31'h0, mie}, 32'h0);

        // Scratch RMW and pre-update read
        do_op(MSR_OP_WRITE, 4'd5, 32'hDEAD_BEEF);
        op = MSR_OP_WRITE; addr = 4'd5; wdata = 32'h1234;
        #1;
        chk("read_is_pre_update", data, 32'hDEAD_BEEF);
        chk("legal_not_illegal", {31'h0, illegal}, 32'h0);
        tick();
        op = MSR_OP_NONE;
        rd(4'd5, 32'h0000_1234, "scratch_write");
        do_op(MSR_OP_SET, 4'd5, 32'hF000_0000);
        rd(4'd5, 32'hF000_1234, "scratch_set");
        do_op(MSR_OP_CLEAR, 4'd5, 32'h0000_1200);
        rd(4'd5, 32'hF000_0034, "scratch_clear");

        // Unimplemented indices on the 12-entry instance
        op12 = MSR_OP_WRITE; addr12 = 4'd4; wdata12 = 32'hA5A5;
        tick();
        op12 = MSR_OP_NONE;
        rd12(4'd4, 32'h0000_A5A5, "n12_scratch");
        op12 = MSR_OP_WRITE; addr12 = 4'd13; wdata12 = 32'hFFFF_FFFF;
        #1;
        chk("n12_illegal_13", {31'h0, illegal12}, 32'h1);
        chk("n12_data_13", data12, 32'h0);
        tick();
        addr12 = 4'd12;
        #1;
        chk("n12_illegal_12", {31'h0, illegal12}, 32'h1);
        tick();
        op12 = MSR_OP_NONE;
        addr12 = 4'd13;
        #1;
        chk("n12_no_op_not_illegal", {31'h0, illegal12}, 32'h0);
        rd12(4'd4, 32'h0000_A5A5, "n12_no_state_change");
        rd12(4'd1, 32'h0, "n12_mtvec_untouched");
        rd12(4'd0, 32'h0, "n12_mstatus_untouched");

        // Counter indices
`ifdef MSR_COUNTERS_EN
        do_op(MSR_OP_WRITE, 4'd12, 32'hFFFF_FFFF);
        rd(4'd12, 32'hFFFF_FFFF, "cycle_lo_written");
        rd(4'd13, 32'h0, "cycle_hi_before_carry");
        tick();
        rd(4'd12, 32'h0, "cycle_lo_wrapped");
        rd(4'd13, 32'h1, "cycle_hi_carry");
        retire = 1'b1;
        repeat (5) tick();
        retire = 1'b0;
        rd(4'd14, 32'h5, "instret_lo_5");
        rd(4'd15, 32'h0, "instret_hi_0");
        do_op(MSR_OP_WRITE, 4'd15, 32'h7);
        rd(4'd15, 32'h7, "instret_hi_written");
`else
        do_op(MSR_OP_WRITE, 4'd12, 32'hFFFF_FFFF);
        tick();
        rd(4'd12, 32'hFFFF_FFFF, "scratch12_holds");
        do_op(MSR_OP_WRITE, 4'd14, 32'hA);
        retire = 1'b1;
        repeat (5) tick();
        retire = 1'b0;
        rd(4'd14, 32'hA, "retire_ignored");
        do_op(MSR_OP_WRITE, 4'd15, 32'h7);
        rd(4'd15, 32'h7, "scratch15_written");
`endif

        // Reset mid-run clears everything
        rst = 1'b0;
        tick();
        rst = 1'b1;
        rd(4'd12, 32'h0, "rst_idx12");
        rd(4'd13, 32'h0, "rst_idx13");
        rd(4'd14, 32'h0, "rst_idx14");
        rd(4'd15, 32'h0, "rst_idx15");
        rd(4'd1, 32'h0, "rst_mtvec_read");
        rd(4'd5, 32'h0, "rst_scratch5");
        rd(4'd0, 32'h0, "rst_mstatus");
        chk("rst_mie", {31'h0, mie}, 32'h0);
        chk("rst_mtvec", mtvec, 32'h0);
        chk("rst_mepc", mepc, 32'h0);
        rd12(4'd4, 32'h0, "rst_n12_scratch");
        chk("rst_n12_ports", {mtvec12[30:0] | mepc12[30:0], mie12}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
